// File: rtl/fmul_rr_scheduler_if.sv
// Handshake/bus bundle between the MAC lanes, the round-robin scheduler and the
// shared FP multiplier.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake (16 bits per lane)
//   mul_a/mul_b/mul_result          : registered operands to, and product from, the multiplier
//   resp_valid/resp_data            : one-hot response pulse plus 32-bit product
//   busy                            : any operation still in flight
// slave  : scheduler side
// master : environment side (requesters plus multiplier)
interface fmul_rr_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic [31:0]          mul_result;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_data;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result,
        output req_ready, mul_a, mul_b, resp_valid, resp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result,
        input  req_ready, mul_a, mul_b, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/fmul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined FP16xFP16->FP32 multiplier among NREQ
// requesters. At most one operand pair is accepted per cycle; it is registered into
// the multiplier, and its owner id is carried through a tag pipe matching the
// multiplier latency so that the product can be steered back as a one-hot pulse.
// Ports:
//   clock  : system clock, rising edge
//   resetn : synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bus    : fmul_rr_scheduler_if.slave (request handshake, multiplier, responses, busy)
module fmul_rr_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic               clock,
    input  logic               resetn,
    fmul_rr_scheduler_if.slave bus
);
    localparam int unsigned IdW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
    // Stage 0 lines up with mul_a/mul_b; last stage lines up with mul_result.
    localparam int unsigned PipeD = MUL_LAT + 1;

    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]  out_cnt_q [NREQ];
    logic [CntW-1:0]  out_cnt_d [NREQ];
    logic [PipeD-1:0] tag_vld_q;
    logic [IdW-1:0]   tag_id_q [PipeD];
    logic [15:0]      mul_a_q, mul_a_d;
    logic [15:0]      mul_b_q, mul_b_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;

    logic [NREQ-1:0]  elig;
    logic             grant_vld;
    logic [IdW-1:0]   grant_id;
    logic             accept;
    logic [15:0]      sel_a, sel_b;
    logic [IdW:0]     sum;
    logic [IdW-1:0]   idx;

    // Eligibility uses the counters as held this cycle; a response pulsing now
    // only frees its slot from the next cycle on.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] && (out_cnt_q[i] < CntW'(MAX_OUT));
        end
    end

    // Search starting at the pointer, ascending with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IdW + 1)'(k);
            if (sum >= (IdW + 1)'(NREQ)) begin
                sum = sum - (IdW + 1)'(NREQ);
            end
            idx = sum[IdW-1:0];
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    assign accept        = grant_vld && !resetn;
    assign bus.req_ready = accept ? (NREQ'(1) << grant_id) : '0;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IdW'(i)) begin
                sel_a = bus.req_a[16*i +: 16];
                sel_b = bus.req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = '0;
        mul_b_d = '0;
        if (accept) begin
            ptr_d   = (grant_id == IdW'(NREQ - 1)) ? '0 : grant_id + IdW'(1);
            mul_a_d = sel_a;
            mul_b_d = sel_b;
        end
    end

    // Accept and response in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (accept && (grant_id == IdW'(i)) && !resp_valid_q[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CntW'(1);
            end else if (resp_valid_q[i] && !(accept && (grant_id == IdW'(i)))) begin
                out_cnt_d[i] = out_cnt_q[i] - CntW'(1);
            end
        end
    end

    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (tag_vld_q[PipeD-1]) begin
            resp_valid_d = NREQ'(1) << tag_id_q[PipeD-1];
            resp_data_d  = bus.mul_result;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            ptr_q        <= '0;
            tag_vld_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= '0;
            end
            for (int s = 0; s < PipeD; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q    <= {tag_vld_q[PipeD-2:0], accept};
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int i = 0; i < NREQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < PipeD; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (out_cnt_q[i] != '0) begin
                bus.busy = 1'b1;
            end
        end
        if (resetn) begin
            bus.busy = 1'b0;
        end
    end

    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// Bench for fmul_rr_scheduler: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level model (credit counts, pointer, and a
// queue of expected responses with due cycles).
module tb_fmul_rr_scheduler;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 5;
    localparam int MAX_OUT = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b1;

    fmul_rr_scheduler_if #(.NREQ(NREQ)) bus ();

    fmul_rr_scheduler #(
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Exact FP16 x FP16 -> FP32 product for normals; subnormal inputs flush to zero.
    function automatic logic [31:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [7:0]  e;
        logic        s;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 31'b0};
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = 8'(a[14:10]) + 8'(b[14:10]) + 8'd97;
        if (p[21]) return {s, e + 8'd1, p[20:0], 2'b0};
        return {s, e, p[19:0], 3'b0};
    endfunction

    // Behavioural multiplier: product of cycle n operands appears in cycle n+MUL_LAT.
    logic [31:0] mpipe [MUL_LAT];
    always @(posedge clock) begin
        mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
        for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign bus.mul_result = mpipe[MUL_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } exp_t;

    int          cnt [NREQ];
    int          ptr       = 0;
    int          cyc       = 0;
    bit          known     = 0;
    logic [31:0] last_data = '0;
    exp_t        q [$];

    function automatic logic [15:0] rnd_fp16();
        if ($urandom_range(0, 7) == 0) return 16'h0000;
        return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    endfunction

    function automatic logic [16*NREQ-1:0] rnd_bus();
        logic [16*NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[16*i +: 16] = rnd_fp16();
        return r;
    endfunction

    // One clock cycle: drive, compare at negedge, advance the model at posedge.
    task automatic step(input logic rst, input logic [NREQ-1:0] v,
                        input logic [16*NREQ-1:0] a, input logic [16*NREQ-1:0] b,
                        output int g, output logic [NREQ-1:0] rv,
                        output logic [31:0] rd, output logic bz);
        int              eg;
        int              idx;
        bit              pulse;
        bit              any;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] erv;
        exp_t            e;
        resetn        = rst;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clock);
        eg = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (eg < 0 && v[idx] && cnt[idx] < MAX_OUT) eg = idx;
            end
        end
        er = (eg >= 0) ? NREQ'(1) << eg : '0;
        check("req_ready", bus.req_ready, er);
        g = -1;
        if ($countones(bus.req_ready) > 1) g = -2;
        else for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        pulse = (q.size() > 0) && (q[0].due == cyc);
        erv   = pulse ? NREQ'(1) << q[0].id : '0;
        if (pulse) last_data = q[0].data;
        any = 0;
        for (int i = 0; i < NREQ; i++) if (cnt[i] != 0) any = 1;
        if (known) begin
            check("resp_valid", bus.resp_valid, erv);
            check("resp_data", bus.resp_data, last_data);
            check("busy", bus.busy, any && !rst);
        end
        rv = bus.resp_valid;
        rd = bus.resp_data;
        bz = bus.busy;
        @(posedge clock);
        if (pulse) begin
            cnt[q[0].id]--;
            q.delete(0);
        end
        if (eg >= 0) begin
            cnt[eg]++;
            e.id   = eg;
            e.due  = cyc + MUL_LAT + 2;
            e.data = fmul(a[16*eg +: 16], b[16*eg +: 16]);
            q.push_back(e);
            ptr = (eg + 1) % NREQ;
        end
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] = 0;
            ptr       = 0;
            last_data = '0;
            q.delete();
            known     = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        int              g;
        logic [NREQ-1:0] rv;
        logic [31:0]     rd;
        logic            bz;
        for (int k = 0; k < n; k++) step(1'b0, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
    endtask

    initial begin
        int                 g;
        logic [NREQ-1:0]    rv;
        logic [31:0]        rd;
        logic               bz;
        logic [16*NREQ-1:0] a;
        logic [16*NREQ-1:0] b;
        logic               rst;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;

        // Reset with every requester valid, then first grant goes to 0.
        for (int k = 0; k < 3; k++) step(1'b1, '1, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t1_rst_busy", bz, 1'b0);
        check("t1_rst_resp_valid", rv, '0);
        step(1'b0, '1, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t1_first_grant", g, 0);
        idle(10);

        // Single op: 1.0 * 2.0 from requester 2.
        a = '0;
        b = '0;
        a[47:32] = 16'h3C00;
        b[47:32] = 16'h4000;
        step(1'b0, 4'b0100, a, b, g, rv, rd, bz);
        check("t2_grant", g, 2);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
            check("t2_resp_valid", rv, (k == 7) ? 4'b0100 : 4'b0000);
        end
        check("t2_resp_data", rd, 32'h4000_0000);
        idle(4);

        // Round robin with all requesters valid.
        step(1'b1, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, '1, rnd_bus(), rnd_bus(), g, rv, rd, bz);
            check("t3_rr_grant", g, k % NREQ);
        end
        idle(10);

        // Credit limit on a single requester.
        step(1'b1, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 4'b0010, rnd_bus(), rnd_bus(), g, rv, rd, bz);
            check("t4_credit_grant", g, (k < 2 || k == 8) ? 1 : -1);
        end
        idle(10);

        // Wrap/skip and pointer hold on idle.
        step(1'b0, 4'b0100, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t5_grant2", g, 2);
        step(1'b0, 4'b0010, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t5_wrap_grant1", g, 1);
        step(1'b0, 4'b0000, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t5_idle_nogrant", g, -1);
        step(1'b0, 4'b1111, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t5_ptr_held", g, 2);
        idle(10);

        // Mid-op reset discards in-flight work.
        for (int k = 0; k < 3; k++) step(1'b0, '1, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        idle(2);
        step(1'b1, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, rnd_bus(), rnd_bus(), g, rv, rd, bz);
            check("t6_no_resp", rv, '0);
            check("t6_busy", bz, 1'b0);
        end
        step(1'b0, '1, rnd_bus(), rnd_bus(), g, rv, rd, bz);
        check("t6_grant_after_rst", g, 0);
        idle(10);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(rst, NREQ'($urandom_range(0, 15) | $urandom_range(0, 15)),
                 rnd_bus(), rnd_bus(), g, rv, rd, bz);
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
